// File: rtl/cnn_layer_accel_pkg.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_pkg
//   Definitions shared by the CNN layer accelerator read-side blocks:
//   - MAX_NUM_INPUT_COLS and the row/column field width derived from it
//   - default read latency of the prefetch buffer (rd_en -> dout)
//   - state encoding of the row sequencer FSM
// -----------------------------------------------------------------------------
package cnn_layer_accel_pkg;

  // Widest expanded (padded/upsampled) input row the prefetch buffer holds.
  localparam int MAX_NUM_INPUT_COLS = 512;

  // Width of every row/column index field. Indices run 0..count-1, so
  // clog2 of the maximum count is enough.
  localparam int C_CLG2_MAX_COLS = $clog2(MAX_NUM_INPUT_COLS);

  // Prefetch buffer read latency: cycles from rd_en to valid dout (1..4).
  localparam int C_RD_LATENCY_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ROW_CHECK  = 3'd1,
    ST_FETCH_REQ  = 3'd2,
    ST_FETCH_WAIT = 3'd3,
    ST_STREAM     = 3'd4,
    ST_ROW_END    = 3'd5,
    ST_DONE       = 3'd6
  } row_seq_state_t;

endpackage : cnn_layer_accel_pkg

// File: rtl/cnn_layer_accel_valid_delay.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_valid_delay
//   Delays a single-bit valid strobe by C_LATENCY cycles so that it lines up
//   with the prefetch buffer's registered dout.
//
// Ports:
//   clk      in  : clock
//   rst_n    in  : asynchronous active-low reset, empties the pipe
//   flush_i  in  : synchronous flush, empties the pipe (job abort)
//   valid_i  in  : strobe entering the pipe (buffer rd_en)
//   valid_o  out : strobe leaving the pipe after C_LATENCY cycles
// -----------------------------------------------------------------------------
module cnn_layer_accel_valid_delay #(
  parameter int C_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic valid_i,
  output logic valid_o
);

  logic [C_LATENCY-1:0] pipe_q;
  logic [C_LATENCY-1:0] pipe_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    pipe_d = pipe_q;
    if (flush_i) begin
      pipe_d = '0;
    end else begin
      pipe_d[0] = valid_i;
      // Loop body is empty when C_LATENCY is 1; stage 0 is then the output.
      for (int i = 1; i < C_LATENCY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  // NOTE: this pipe carries control, not data, so it must be reset; a stale
  // bit here would report a pixel that was never read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign valid_o = pipe_q[C_LATENCY-1];

endmodule : cnn_layer_accel_valid_delay

// File: rtl/cnn_layer_accel_row_sequencer.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_row_sequencer
//   Read-side sequencer for cnn_layer_accel_prefetch_buffer. Walks the expanded
//   input plane row by row and column by column, requests a DMA row fetch only
//   when the buffer does not cancel it, and produces a pixel-valid strobe
//   aligned with the buffer's dout.
//
// Ports:
//   clk                 in  : single clock (also the buffer's rd_clk)
//   rst_n               in  : asynchronous active-low reset
//   start               in  : one-cycle job start, honoured only in IDLE
//   job_abort           in  : synchronous abort back to IDLE
//   expd_num_input_cols in  : last expanded column index, latched at start
//   expd_num_input_rows in  : last expanded row index, latched at start
//   cncl_fetch_req      in  : buffer says current row needs no fetch
//   fetch_req           out : row fetch request, held until fetch_grant
//   fetch_grant         in  : one-cycle DMA accept
//   row_fetched         in  : one-cycle pulse, row fully written to buffer
//   out_ready           in  : downstream accepts a pixel this cycle
//   rd_en               out : buffer read enable
//   input_col           out : current column to the buffer
//   input_row           out : current row to the buffer
//   rst_addr            out : buffer read-pointer reset pulse
//   job_fetch_ack       out : one-cycle pulse when a job is accepted
//   job_complete_ack    out : one-cycle pulse when a job completes
//   pix_valid           out : buffer dout valid this cycle
//   busy                out : high in every state except IDLE
// -----------------------------------------------------------------------------
module cnn_layer_accel_row_sequencer
  import cnn_layer_accel_pkg::*;
#(
  parameter int C_CLG2_ROW_BUF_BRAM_DEPTH = C_CLG2_MAX_COLS,
  parameter int C_RD_LATENCY              = C_RD_LATENCY_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 job_abort,
  input  logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] expd_num_input_cols,
  input  logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] expd_num_input_rows,
  input  logic                                 cncl_fetch_req,
  output logic                                 fetch_req,
  input  logic                                 fetch_grant,
  input  logic                                 row_fetched,
  input  logic                                 out_ready,
  output logic                                 rd_en,
  output logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] input_col,
  output logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] input_row,
  output logic                                 rst_addr,
  output logic                                 job_fetch_ack,
  output logic                                 job_complete_ack,
  output logic                                 pix_valid,
  output logic                                 busy
);

  localparam int W = C_CLG2_ROW_BUF_BRAM_DEPTH;
  localparam logic [W-1:0] C_ONE = W'(1);

  row_seq_state_t state_q;

  logic [W-1:0] last_col_q;
  logic [W-1:0] last_row_q;
  logic [W-1:0] input_col_q;
  logic [W-1:0] input_row_q;
  logic         fetch_req_q;
  logic         rst_addr_q;
  logic         job_fetch_ack_q;
  logic         job_complete_ack_q;

  logic         rd_en_w;
  logic         last_col_w;
  logic         last_row_w;

  // rd_en follows out_ready combinationally so a stall releases without a
  // bubble. It is suppressed in an abort cycle so no read is left in flight
  // after the valid pipe is flushed.
  assign rd_en_w    = (state_q == ST_STREAM) && out_ready && !job_abort;
  assign last_col_w = (input_col_q == last_col_q);
  assign last_row_w = (input_row_q == last_row_q);

  // ---------------------------------------------------------------------------
  // Sequencer FSM. Pulse outputs default low every cycle and are set on the
  // transition into the state that owns them, so each is high for exactly the
  // cycle spent in that state.
  // ---------------------------------------------------------------------------
  // NOTE: state and outputs here are flops, so they take non-blocking
  // assignments only; that keeps every read in this block on pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      last_col_q         <= '0;
      last_row_q         <= '0;
      input_col_q        <= '0;
      input_row_q        <= '0;
      fetch_req_q        <= 1'b0;
      rst_addr_q         <= 1'b0;
      job_fetch_ack_q    <= 1'b0;
      job_complete_ack_q <= 1'b0;
    end else begin
      rst_addr_q         <= 1'b0;
      job_fetch_ack_q    <= 1'b0;
      job_complete_ack_q <= 1'b0;

      if (job_abort) begin
        // Abort outranks everything, including a start seen in IDLE.
        state_q     <= ST_IDLE;
        input_col_q <= '0;
        input_row_q <= '0;
        fetch_req_q <= 1'b0;
        rst_addr_q  <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              last_col_q      <= expd_num_input_cols;
              last_row_q      <= expd_num_input_rows;
              input_col_q     <= '0;
              input_row_q     <= '0;
              job_fetch_ack_q <= 1'b1;
              state_q         <= ST_ROW_CHECK;
            end
          end

          // Padding and repeated rows are already in the buffer (or are
          // synthesised by it), so they stream without a DMA round trip.
          ST_ROW_CHECK: begin
            if (cncl_fetch_req) begin
              state_q <= ST_STREAM;
            end else begin
              fetch_req_q <= 1'b1;
              state_q     <= ST_FETCH_REQ;
            end
          end

          ST_FETCH_REQ: begin
            if (fetch_grant) begin
              fetch_req_q <= 1'b0;
              state_q     <= ST_FETCH_WAIT;
            end
          end

          ST_FETCH_WAIT: begin
            if (row_fetched) begin
              state_q <= ST_STREAM;
            end
          end

          // Compare before increment: the last column index is never
          // stepped past, so the counter cannot wrap for any dimension.
          ST_STREAM: begin
            if (rd_en_w) begin
              if (last_col_w) begin
                rst_addr_q <= 1'b1;
                state_q    <= ST_ROW_END;
              end else begin
                input_col_q <= input_col_q + C_ONE;
              end
            end
          end

          ST_ROW_END: begin
            input_col_q <= '0;
            if (last_row_w) begin
              job_complete_ack_q <= 1'b1;
              state_q            <= ST_DONE;
            end else begin
              input_row_q <= input_row_q + C_ONE;
              state_q     <= ST_ROW_CHECK;
            end
          end

          ST_DONE: begin
            state_q <= ST_IDLE;
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // pix_valid: rd_en delayed to line up with the buffer's dout.
  // ---------------------------------------------------------------------------
  cnn_layer_accel_valid_delay #(
    .C_LATENCY (C_RD_LATENCY)
  ) u_valid_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (job_abort),
    .valid_i (rd_en_w),
    .valid_o (pix_valid)
  );

  assign fetch_req        = fetch_req_q;
  assign rd_en            = rd_en_w;
  assign input_col        = input_col_q;
  assign input_row        = input_row_q;
  assign rst_addr         = rst_addr_q;
  assign job_fetch_ack    = job_fetch_ack_q;
  assign job_complete_ack = job_complete_ack_q;
  assign busy             = (state_q != ST_IDLE);

endmodule : cnn_layer_accel_row_sequencer

// File: tb/tb_cnn_layer_accel_row_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cnn_layer_accel_row_sequencer
//   Directed bench for the row sequencer. Inputs change on the falling edge,
//   outputs are checked 1 ns later; event counters sample on the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cnn_layer_accel_row_sequencer;
  import cnn_layer_accel_pkg::*;

  localparam int W = C_CLG2_MAX_COLS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         job_abort = 1'b0;
  logic [W-1:0] expd_num_input_cols = '0;
  logic [W-1:0] expd_num_input_rows = '0;
  logic         cncl_fetch_req;
  logic         fetch_req;
  logic         fetch_grant;
  logic         row_fetched;
  logic         out_ready = 1'b0;
  logic         rd_en;
  logic [W-1:0] input_col;
  logic [W-1:0] input_row;
  logic         rst_addr;
  logic         job_fetch_ack;
  logic         job_complete_ack;
  logic         pix_valid;
  logic         busy;

  // Buffer/DMA models
  logic [7:0]   cncl_mask = '0;
  logic         dma_auto = 1'b0;
  logic         dma_grant = 1'b0;
  logic         dma_fetched = 1'b0;
  logic         man_grant = 1'b0;
  logic         man_fetched = 1'b0;
  int           req_cnt = 0;
  int           wait_cnt = 0;

  // Scoreboard counts and logs
  int           n_compared = 0;
  int           n_mismatched = 0;
  int           n_hs = 0, n_rd = 0, n_rst = 0, n_done = 0, cyc = 0;
  int           col_log[$];
  int           row_log[$];
  int           rd_cyc[$];
  int           hs_row[$];
  logic         chk_lat = 1'b0;
  logic [1:0]   rd_hist = '0;

  // Snapshot bases for per-test deltas
  int           b_hs, b_rd, b_rst, b_done, b_log, b_hsl;

  always #5 clk = ~clk;

  assign cncl_fetch_req = cncl_mask[input_row[2:0]] & (input_row[W-1:3] == '0);
  assign fetch_grant    = dma_grant | man_grant;
  assign row_fetched    = dma_fetched | man_fetched;

  cnn_layer_accel_row_sequencer #(
    .C_CLG2_ROW_BUF_BRAM_DEPTH (W),
    .C_RD_LATENCY              (2)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .job_abort           (job_abort),
    .expd_num_input_cols (expd_num_input_cols),
    .expd_num_input_rows (expd_num_input_rows),
    .cncl_fetch_req      (cncl_fetch_req),
    .fetch_req           (fetch_req),
    .fetch_grant         (fetch_grant),
    .row_fetched         (row_fetched),
    .out_ready           (out_ready),
    .rd_en               (rd_en),
    .input_col           (input_col),
    .input_row           (input_row),
    .rst_addr            (rst_addr),
    .job_fetch_ack       (job_fetch_ack),
    .job_complete_ack    (job_complete_ack),
    .pix_valid           (pix_valid),
    .busy                (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] flags();
    return {fetch_req, rd_en, rst_addr, job_fetch_ack, job_complete_ack, pix_valid, busy};
  endfunction

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (job_complete_ack !== 1'b1 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, 32'(job_complete_ack), 32'd1);
  endtask

  task automatic snap();
    b_hs = n_hs; b_rd = n_rd; b_rst = n_rst; b_done = n_done;
    b_log = col_log.size(); b_hsl = hs_row.size();
  endtask

  // DMA responder: grant 2 cycles after fetch_req rises, row_fetched 2
  // cycles after the grant.
  always @(negedge clk) begin
    dma_grant   <= 1'b0;
    dma_fetched <= 1'b0;
    if (!dma_auto || !rst_n) begin
      req_cnt  <= 0;
      wait_cnt <= 0;
    end else if (fetch_req) begin
      if (req_cnt == 2) begin
        dma_grant <= 1'b1;
        req_cnt   <= 0;
        wait_cnt  <= 1;
      end else begin
        req_cnt <= req_cnt + 1;
      end
    end else if (wait_cnt != 0) begin
      if (wait_cnt == 2) begin
        dma_fetched <= 1'b1;
        wait_cnt    <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Event monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fetch_req && fetch_grant) begin
      n_hs <= n_hs + 1;
      hs_row.push_back(int'(input_row));
    end
    if (rd_en) begin
      n_rd <= n_rd + 1;
      col_log.push_back(int'(input_col));
      row_log.push_back(int'(input_row));
      rd_cyc.push_back(cyc);
    end
    if (rst_addr)         n_rst  <= n_rst + 1;
    if (job_complete_ack) n_done <= n_done + 1;
    if (chk_lat) check("pix_valid_lat2", 32'(pix_valid), 32'(rd_hist[1]));
    rd_hist <= {rd_hist[0], rd_en};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    @(negedge clk); #1;
    check("reset_flags", 32'(flags()), 32'd0);
    check("reset_col", 32'(input_col), 32'd0);
    check("reset_row", 32'(input_row), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("idle_busy", 32'(busy), 32'd0);

    // ---------------- 4x3 plane, all rows fetched ----------------
    dma_auto = 1'b1;
    cncl_mask = 8'h00;
    snap();
    @(negedge clk);
    start = 1'b1; expd_num_input_cols = W'(3); expd_num_input_rows = W'(2);
    #1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("t1_fetch_ack", 32'(job_fetch_ack), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_no_req_t1", 32'(fetch_req), 32'd0);
    @(negedge clk); #1;
    check("t1_req_t2", 32'(fetch_req), 32'd1);
    wait_done(200, "t1_done");
    @(negedge clk); #1;
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_hs", 32'(n_hs - b_hs), 32'd3);
    check("t1_rd", 32'(n_rd - b_rd), 32'd12);
    check("t1_rst_addr", 32'(n_rst - b_rst), 32'd3);
    check("t1_complete", 32'(n_done - b_done), 32'd1);
    for (int i = 0; i < 12; i++) begin
      check("t1_col_seq", 32'(col_log[b_log + i]), 32'(i % 4));
      check("t1_row_seq", 32'(row_log[b_log + i]), 32'(i / 4));
    end

    // ---------------- 2x6 plane, rows 0 and 5 cancelled ----------------
    cncl_mask = 8'b0010_0001;
    snap();
    @(negedge clk);
    start = 1'b1; expd_num_input_cols = W'(1); expd_num_input_rows = W'(5);
    #1;
    @(negedge clk);
    start = 1'b0;
    #1;
    wait_done(300, "t2_done");
    check("t2_hs", 32'(n_hs - b_hs), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2_hs_row", 32'(hs_row[b_hsl + i]), 32'(i + 1));
    end
    check("t2_rd", 32'(n_rd - b_rd), 32'd12);
    check("t2_rst_addr", 32'(n_rst - b_rst), 32'd6);
    check("t2_turnaround", 32'(rd_cyc[b_log + 10] - rd_cyc[b_log + 9]), 32'd3);

    // ---------------- out_ready stall 1-0-0-1 ----------------
    dma_auto = 1'b0;
    cncl_mask = 8'hFF;
    chk_lat = 1'b1;
    snap();
    @(negedge clk);
    start = 1'b1; expd_num_input_cols = W'(7); expd_num_input_rows = W'(0);
    #1;
    @(negedge clk);
    start = 1'b0;
    #1;
    @(negedge clk); out_ready = 1'b1; #1;
    check("t3_rd_a", 32'(rd_en), 32'd1);
    check("t3_col_a", 32'(input_col), 32'd0);
    @(negedge clk); out_ready = 1'b0; #1;
    check("t3_rd_b", 32'(rd_en), 32'd0);
    check("t3_col_b", 32'(input_col), 32'd1);
    @(negedge clk); out_ready = 1'b0; #1;
    check("t3_rd_c", 32'(rd_en), 32'd0);
    check("t3_col_hold", 32'(input_col), 32'd1);
    check("t3_pv_c", 32'(pix_valid), 32'd1);
    @(negedge clk); out_ready = 1'b1; #1;
    check("t3_rd_resume", 32'(rd_en), 32'd1);
    check("t3_col_resume", 32'(input_col), 32'd1);
    check("t3_pv_d", 32'(pix_valid), 32'd0);
    @(negedge clk); #1;
    check("t3_col_e", 32'(input_col), 32'd2);
    @(negedge clk); #1;
    check("t3_pv_f", 32'(pix_valid), 32'd1);
    wait_done(100, "t3_done");
    chk_lat = 1'b0;
    check("t3_rd", 32'(n_rd - b_rd), 32'd8);

    // ---------------- abort in FETCH_WAIT ----------------
    cncl_mask = 8'h00;
    @(negedge clk); #1;
    snap();
    @(negedge clk);
    start = 1'b1; expd_num_input_cols = W'(3); expd_num_input_rows = W'(2);
    #1;
    @(negedge clk);
    start = 1'b0;
    #1;
    @(negedge clk); man_grant = 1'b1; #1;
    check("t4_req", 32'(fetch_req), 32'd1);
    @(negedge clk); man_grant = 1'b0; #1;
    check("t4_req_granted", 32'(fetch_req), 32'd0);
    check("t4_busy_wait", 32'(busy), 32'd1);
    @(negedge clk); job_abort = 1'b1; #1;
    check("t4_no_rst_yet", 32'(rst_addr), 32'd0);
    @(negedge clk); job_abort = 1'b0; #1;
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_rst_addr", 32'(rst_addr), 32'd1);
    check("t4_req_off", 32'(fetch_req), 32'd0);
    @(negedge clk); man_fetched = 1'b1; #1;
    check("t4_rst_pulse", 32'(rst_addr), 32'd0);
    @(negedge clk); man_fetched = 1'b0; #1;
    check("t4_fetched_ignored", 32'(busy), 32'd0);
    check("t4_rst_count", 32'(n_rst - b_rst), 32'd1);
    check("t4_no_complete", 32'(n_done - b_done), 32'd0);
    // Restart after abort begins at row 0.
    cncl_mask = 8'hFF;
    snap();
    @(negedge clk);
    start = 1'b1; expd_num_input_cols = W'(0); expd_num_input_rows = W'(1);
    #1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("t4_restart_ack", 32'(job_fetch_ack), 32'd1);
    check("t4_restart_row", 32'(input_row), 32'd0);
    wait_done(50, "t4_restart_done");
    check("t4_restart_rd", 32'(n_rd - b_rd), 32'd2);
    check("t4_restart_row0", 32'(row_log[b_log]), 32'd0);
    check("t4_restart_row1", 32'(row_log[b_log + 1]), 32'd1);

    // ---------------- abort together with start in IDLE ----------------
    @(negedge clk);
    start = 1'b1; job_abort = 1'b1;
    #1;
    @(negedge clk);
    start = 1'b0; job_abort = 1'b0;
    #1;
    check("t5_abort_wins_busy", 32'(busy), 32'd0);
    check("t5_abort_wins_ack", 32'(job_fetch_ack), 32'd0);
    check("t5_abort_rst_addr", 32'(rst_addr), 32'd1);

    // ---------------- reset mid-STREAM ----------------
    @(negedge clk);
    start = 1'b1; expd_num_input_cols = W'(7); expd_num_input_rows = W'(0);
    #1;
    @(negedge clk); start = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("t6_pre_pv", 32'(pix_valid), 32'd1);
    check("t6_pre_col", 32'(input_col), 32'd2);
    @(negedge clk); rst_n = 1'b0; #1;
    check("t6_rst_flags", 32'(flags()), 32'd0);
    check("t6_rst_col", 32'(input_col), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("t6_pv_after_a", 32'(pix_valid), 32'd0);
    @(negedge clk); #1;
    check("t6_pv_after_b", 32'(pix_valid), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);

    // ---------------- single-pixel job, start while busy ignored ----------------
    snap();
    @(negedge clk);
    start = 1'b1; expd_num_input_cols = W'(0); expd_num_input_rows = W'(0);
    #1;
    @(negedge clk); start = 1'b0; #1;
    @(negedge clk); start = 1'b1; #1;
    check("t7_rd", 32'(rd_en), 32'd1);
    check("t7_col", 32'(input_col), 32'd0);
    @(negedge clk); start = 1'b0; #1;
    check("t7_busy_start_ignored", 32'(job_fetch_ack), 32'd0);
    check("t7_row_end_rst", 32'(rst_addr), 32'd1);
    check("t7_row_end_rd", 32'(rd_en), 32'd0);
    @(negedge clk); #1;
    check("t7_done_ack", 32'(job_complete_ack), 32'd1);
    check("t7_done_rst", 32'(rst_addr), 32'd0);
    @(negedge clk); #1;
    check("t7_idle", 32'(busy), 32'd0);
    check("t7_ack_pulse", 32'(job_complete_ack), 32'd0);
    check("t7_rd_count", 32'(n_rd - b_rd), 32'd1);
    check("t7_rst_count", 32'(n_rst - b_rst), 32'd1);
    check("t7_done_count", 32'(n_done - b_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_cnn_layer_accel_row_sequencer
